// File: rtl/wb_regfile.sv
// Writeback stage and 32x32 general-purpose register file: load extract, result select, commit, read ports.
// Define WB_BYPASS_EN to make a same-cycle writeback visible on RD1/RD2.
module wb_regfile #(
  parameter int NREG  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             linkW,
  input  logic             RegWriteW,
  input  logic             MemOrALUW,
  input  logic [2:0]       MemOutSelW,
  input  logic [31:0]      linkAddrW,
  input  logic [31:0]      ALUoutW,
  input  logic [31:0]      CP0OutW,
  input  logic [31:0]      pcW,
  input  logic [4:0]       A3W,
  input  logic [31:0]      HIW,
  input  logic [31:0]      LOW,
  input  logic             HLToRegW,
  input  logic             HIReadW,
  input  logic             CP0ToRegW,
  input  logic [31:0]      MemRdataW,
  input  logic [4:0]       A1,
  input  logic [4:0]       A2,
  output logic [31:0]      RD1,
  output logic [31:0]      RD2,
  output logic [31:0]      WDW,
  output logic             WeW,
  output logic [CNT_W-1:0] wr_cnt
);

  typedef enum logic [2:0] {
    LD_LW  = 3'd0,
    LD_LB  = 3'd1,
    LD_LBU = 3'd2,
    LD_LH  = 3'd3,
    LD_LHU = 3'd4
  } ldSel_e;

  logic [NREG-1:0][31:0] rf;
  logic [31:0]           memWord;
  logic [7:0]            ldByte;
  logic [15:0]           ldHalf;
  logic [31:0]           ldData;
  logic [31:0]           rdArr1;
  logic [31:0]           rdArr2;
  logic [CNT_W-1:0]      wrCnt;

  // pcW is carried for debug visibility only; it does not affect the result.
  logic unusedPc;
  assign unusedPc = ^pcW;

  assign memWord = MemRdataW;
  assign ldByte  = 8'(memWord >> {ALUoutW[1:0], 3'b000});
  assign ldHalf  = ALUoutW[1] ? memWord[31:16] : memWord[15:0];

  always_comb begin
    ldData = memWord;
    case (MemOutSelW)
      LD_LB:   ldData = {{24{ldByte[7]}}, ldByte};
      LD_LBU:  ldData = {24'h0, ldByte};
      LD_LH:   ldData = {{16{ldHalf[15]}}, ldHalf};
      LD_LHU:  ldData = {16'h0, ldHalf};
      default: ldData = memWord;
    endcase
  end

  always_comb begin
    WDW = ALUoutW;
    if (linkW)          WDW = linkAddrW;
    else if (CP0ToRegW) WDW = CP0OutW;
    else if (HLToRegW)  WDW = HIReadW ? HIW : LOW;
    else if (MemOrALUW) WDW = ldData;
  end

  // Gating with RegWriteW first keeps an unknown A3W out of the array when no write is requested.
  assign WeW = RegWriteW & (A3W != 5'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      wrCnt <= '0;
    end else if (WeW) begin
      if (32'(A3W) < NREG) rf[A3W] <= WDW;
      wrCnt <= wrCnt + CNT_W'(1);
    end
  end

  assign wr_cnt = wrCnt;

  function automatic logic [31:0] rdArr(input logic [4:0] a, input logic [NREG-1:0][31:0] arr);
    if (a == 5'd0 || 32'(a) >= NREG) return 32'h0;
    return arr[a];
  endfunction

  assign rdArr1 = rdArr(A1, rf);
  assign rdArr2 = rdArr(A2, rf);

`ifdef WB_BYPASS_EN
  assign RD1 = (WeW && A1 == A3W) ? WDW : rdArr1;
  assign RD2 = (WeW && A2 == A3W) ? WDW : rdArr2;
`else
  assign RD1 = rdArr1;
  assign RD2 = rdArr2;
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile: commits queue their expected register value, read back after the edge.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic        linkW, RegWriteW, MemOrALUW, HLToRegW, HIReadW, CP0ToRegW;
  logic [2:0]  MemOutSelW;
  logic [31:0] linkAddrW, ALUoutW, CP0OutW, pcW, HIW, LOW, MemRdataW;
  logic [4:0]  A3W, A1, A2;
  logic [31:0] RD1, RD2, WDW, rd1W, rd2W, wdwW;
  logic        WeW, weWW;
  logic [31:0] wrCnt;
  logic [3:0]  cntW;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } sbE_t;

  sbE_t        sbQ[$];
  logic [31:0] mdl[32];
  logic [31:0] mdlCnt;
  int          nChk = 0;
  int          nBad = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .reset(reset), .linkW(linkW), .RegWriteW(RegWriteW), .MemOrALUW(MemOrALUW),
    .MemOutSelW(MemOutSelW), .linkAddrW(linkAddrW), .ALUoutW(ALUoutW), .CP0OutW(CP0OutW),
    .pcW(pcW), .A3W(A3W), .HIW(HIW), .LOW(LOW), .HLToRegW(HLToRegW), .HIReadW(HIReadW),
    .CP0ToRegW(CP0ToRegW), .MemRdataW(MemRdataW), .A1(A1), .A2(A2), .RD1(RD1), .RD2(RD2),
    .WDW(WDW), .WeW(WeW), .wr_cnt(wrCnt)
  );

  wb_regfile #(.CNT_W(4)) dutW (
    .clk(clk), .reset(reset), .linkW(linkW), .RegWriteW(RegWriteW), .MemOrALUW(MemOrALUW),
    .MemOutSelW(MemOutSelW), .linkAddrW(linkAddrW), .ALUoutW(ALUoutW), .CP0OutW(CP0OutW),
    .pcW(pcW), .A3W(A3W), .HIW(HIW), .LOW(LOW), .HLToRegW(HLToRegW), .HIReadW(HIReadW),
    .CP0ToRegW(CP0ToRegW), .MemRdataW(MemRdataW), .A1(A1), .A2(A2), .RD1(rd1W), .RD2(rd2W),
    .WDW(wdwW), .WeW(weWW), .wr_cnt(cntW)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChk++;
    if (got !== exp) begin
      nBad++;
      $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
    end
  endtask

  task automatic clrCtl();
    linkW = 0; RegWriteW = 0; MemOrALUW = 0; HLToRegW = 0; HIReadW = 0; CP0ToRegW = 0;
    MemOutSelW = 0; linkAddrW = 0; ALUoutW = 0; CP0OutW = 0; pcW = 0; HIW = 0; LOW = 0;
    MemRdataW = 0; A3W = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Caller sets the data-path controls; this drives the write, checks WDW, pushes the expectation,
  // clocks, then pops it and reads the register back on both ports.
  task automatic commit(input string tag, input logic [4:0] a3, input logic [31:0] exp);
    sbE_t e;
    RegWriteW = 1; A3W = a3;
    #1;
    chk({tag, "_wdw"}, WDW, exp);
    chk({tag, "_we"}, {31'b0, WeW}, {31'b0, a3 != 5'd0});
    sbQ.push_back('{a: a3, d: (a3 == 5'd0) ? 32'h0 : exp});
    if (a3 != 5'd0) begin
      mdl[a3] = exp;
      mdlCnt++;
    end
    step();
    clrCtl();
    e = sbQ.pop_front();
    A1 = e.a; A2 = e.a;
    #1;
    chk({tag, "_rd1"}, RD1, e.d);
    chk({tag, "_rd2"}, RD2, e.d);
    chk({tag, "_cnt"}, wrCnt, mdlCnt);
    chk({tag, "_cntw"}, {28'b0, cntW}, {28'b0, mdlCnt[3:0]});
  endtask

  task automatic doReset();
    reset = 1;
    step();
    reset = 0;
    for (int i = 0; i < 32; i++) mdl[i] = 0;
    mdlCnt = 0;
  endtask

  initial begin
    clrCtl();
    A1 = 0; A2 = 0;
    doReset();
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(31 - i);
      #1;
      chk("rst_rd1", RD1, 32'h0);
      chk("rst_rd2", RD2, 32'h0);
    end
    chk("rst_cnt", wrCnt, 32'h0);

    ALUoutW = 32'h12345678;
    commit("alu", 5'd5, 32'h12345678);

    MemRdataW = 32'h80FF7F01; MemOrALUW = 1; MemOutSelW = 3'd1; ALUoutW = 3;
    commit("lb3", 5'd8, 32'hFFFFFF80);
    MemRdataW = 32'h80FF7F01; MemOrALUW = 1; MemOutSelW = 3'd1; ALUoutW = 1;
    commit("lb1", 5'd8, 32'h0000007F);
    MemRdataW = 32'h80FF7F01; MemOrALUW = 1; MemOutSelW = 3'd2; ALUoutW = 3;
    commit("lbu3", 5'd9, 32'h00000080);
    MemRdataW = 32'h80FF7F01; MemOrALUW = 1; MemOutSelW = 3'd3; ALUoutW = 2;
    commit("lh2", 5'd10, 32'hFFFF80FF);
    MemRdataW = 32'h80FF7F01; MemOrALUW = 1; MemOutSelW = 3'd4; ALUoutW = 0;
    commit("lhu0", 5'd11, 32'h00007F01);
    MemRdataW = 32'h80FF7F01; MemOrALUW = 1; MemOutSelW = 3'd0; ALUoutW = 3;
    commit("lw", 5'd12, 32'h80FF7F01);
    MemRdataW = 32'h80FF7F01; MemOrALUW = 1; MemOutSelW = 3'd7; ALUoutW = 2;
    commit("lw7", 5'd13, 32'h80FF7F01);

    linkW = 1; CP0ToRegW = 1; linkAddrW = 32'h00400010; CP0OutW = 32'h00000BAD; HLToRegW = 1;
    commit("link", 5'd31, 32'h00400010);
    CP0ToRegW = 1; CP0OutW = 32'h00000BAD; HLToRegW = 1; HIW = 32'hBEEF; MemOrALUW = 1;
    commit("cp0", 5'd14, 32'h00000BAD);
    HLToRegW = 1; HIReadW = 0; HIW = 32'hBEEF; LOW = 32'hDEAD; MemOrALUW = 1;
    commit("lo", 5'd15, 32'h0000DEAD);
    HLToRegW = 1; HIReadW = 1; HIW = 32'hBEEF; LOW = 32'hDEAD;
    commit("hi", 5'd16, 32'h0000BEEF);
    ALUoutW = 32'hFFFF0000;
    commit("r0", 5'd0, 32'hFFFF0000);

    ALUoutW = 32'h1;
    commit("r7pre", 5'd7, 32'h1);
    ALUoutW = 32'hCAFEF00D; RegWriteW = 1; A3W = 7; A1 = 7; A2 = 5;
    #1;
`ifdef WB_BYPASS_EN
    chk("byp_same", RD1, 32'hCAFEF00D);
`else
    chk("byp_same", RD1, 32'h1);
`endif
    chk("byp_other", RD2, 32'h12345678);
    commit("byp_next", 5'd7, 32'hCAFEF00D);

    for (int i = 0; i < 12; i++) begin
      ALUoutW = $urandom;
      commit("rnd", 5'($urandom_range(1, 31)), ALUoutW);
    end
    for (int i = 0; i < 32; i++) begin
      A1 = 5'(i); A2 = 5'(i);
      #1;
      chk("sweep", RD1, mdl[i]);
    end

    reset = 1; RegWriteW = 1; A3W = 3; ALUoutW = 32'h55;
    step();
    reset = 0;
    clrCtl();
    for (int i = 0; i < 32; i++) mdl[i] = 0;
    mdlCnt = 0;
    A1 = 3;
    #1;
    chk("rcol_rd", RD1, 32'h0);
    chk("rcol_cnt", wrCnt, 32'h0);
    chk("rcol_cntw", {28'b0, cntW}, 32'h0);

    for (int i = 0; i < 16; i++) begin
      ALUoutW = 32'(i) * 32'h01010101;
      commit("wrap", 5'(1 + i), ALUoutW);
    end
    chk("wrap_zero", {28'b0, cntW}, 32'h0);
    chk("wrap_wide", wrCnt, 32'd16);

    $display("test done: total=%0d bad=%0d", nChk, nBad);
    $finish;
  end

endmodule
